// File: rtl/mul_share_ctrl.sv
// mul_share_ctrl: shares one combinational 5x5 multiplier between two
// requesters. Round-robin grant into a single operand stage, then a
// one-entry result buffer per requester that catches the product one
// cycle later.
module mul_share_ctrl #(
  parameter int unsigned OP_W  = 5,
  parameter int unsigned RES_W = 10
) (
  input  logic             clock,
  input  logic             reset,
  input  logic             req0_valid,
  input  logic [OP_W-1:0]  req0_a,
  input  logic [OP_W-1:0]  req0_b,
  output logic             req0_ready,
  input  logic             req1_valid,
  input  logic [OP_W-1:0]  req1_a,
  input  logic [OP_W-1:0]  req1_b,
  output logic             req1_ready,
  output logic             res0_valid,
  output logic [RES_W-1:0] res0_data,
  output logic             res0_ovf,
  input  logic             res0_ready,
  output logic             res1_valid,
  output logic [RES_W-1:0] res1_data,
  output logic             res1_ovf,
  input  logic             res1_ready,
  output logic [OP_W-1:0]  mul_a,
  output logic [OP_W-1:0]  mul_b,
  input  logic [RES_W-1:0] mul_result,
  input  logic             mul_overflow,
  output logic             busy
);

  logic             op_valid_q, op_valid_d;
  logic             op_owner_q, op_owner_d;
  logic [OP_W-1:0]  mul_a_q, mul_a_d;
  logic [OP_W-1:0]  mul_b_q, mul_b_d;
  logic             rr_q, rr_d;
  logic             res0_valid_q, res0_valid_d;
  logic [RES_W-1:0] res0_data_q, res0_data_d;
  logic             res0_ovf_q, res0_ovf_d;
  logic             res1_valid_q, res1_valid_d;
  logic [RES_W-1:0] res1_data_q, res1_data_d;
  logic             res1_ovf_q, res1_ovf_d;
  logic             busy_q, busy_d;

  logic grantable0, grantable1;
  logic cand0, cand1;
  logic grant0, grant1;

  // Arbitration: a requester may not issue while its own op is in flight
  // or while its result buffer is full and not being drained this cycle.
  always_comb begin
    grantable0 = !(op_valid_q && !op_owner_q) && (!res0_valid_q || res0_ready);
    grantable1 = !(op_valid_q &&  op_owner_q) && (!res1_valid_q || res1_ready);
    cand0      = req0_valid && grantable0;
    cand1      = req1_valid && grantable1;
    grant0     = !reset && cand0 && (!cand1 || !rr_q);
    grant1     = !reset && cand1 && (!cand0 ||  rr_q);
  end

  // Next state: operand stage load, result capture (wins over drain), busy.
  always_comb begin
    op_valid_d   = 1'b0;
    op_owner_d   = op_owner_q;
    mul_a_d      = mul_a_q;
    mul_b_d      = mul_b_q;
    rr_d         = rr_q;
    res0_valid_d = res0_valid_q;
    res0_data_d  = res0_data_q;
    res0_ovf_d   = res0_ovf_q;
    res1_valid_d = res1_valid_q;
    res1_data_d  = res1_data_q;
    res1_ovf_d   = res1_ovf_q;

    if (grant0) begin
      op_valid_d = 1'b1;
      op_owner_d = 1'b0;
      mul_a_d    = req0_a;
      mul_b_d    = req0_b;
      rr_d       = 1'b1;
    end else if (grant1) begin
      op_valid_d = 1'b1;
      op_owner_d = 1'b1;
      mul_a_d    = req1_a;
      mul_b_d    = req1_b;
      rr_d       = 1'b0;
    end

    if (res0_valid_q && res0_ready) res0_valid_d = 1'b0;
    if (res1_valid_q && res1_ready) res1_valid_d = 1'b0;

    if (op_valid_q && !op_owner_q) begin
      res0_valid_d = 1'b1;
      res0_data_d  = mul_result;
      res0_ovf_d   = mul_overflow;
    end
    if (op_valid_q && op_owner_q) begin
      res1_valid_d = 1'b1;
      res1_data_d  = mul_result;
      res1_ovf_d   = mul_overflow;
    end

    busy_d = op_valid_d | res0_valid_d | res1_valid_d;
  end

  // State registers with synchronous active-high reset.
  always_ff @(posedge clock) begin
    if (reset) begin
      op_valid_q   <= 1'b0;
      op_owner_q   <= 1'b0;
      mul_a_q      <= '0;
      mul_b_q      <= '0;
      rr_q         <= 1'b0;
      res0_valid_q <= 1'b0;
      res0_data_q  <= '0;
      res0_ovf_q   <= 1'b0;
      res1_valid_q <= 1'b0;
      res1_data_q  <= '0;
      res1_ovf_q   <= 1'b0;
      busy_q       <= 1'b0;
    end else begin
      op_valid_q   <= op_valid_d;
      op_owner_q   <= op_owner_d;
      mul_a_q      <= mul_a_d;
      mul_b_q      <= mul_b_d;
      rr_q         <= rr_d;
      res0_valid_q <= res0_valid_d;
      res0_data_q  <= res0_data_d;
      res0_ovf_q   <= res0_ovf_d;
      res1_valid_q <= res1_valid_d;
      res1_data_q  <= res1_data_d;
      res1_ovf_q   <= res1_ovf_d;
      busy_q       <= busy_d;
    end
  end

  assign req0_ready = grant0;
  assign req1_ready = grant1;
  assign res0_valid = res0_valid_q;
  assign res0_data  = res0_data_q;
  assign res0_ovf   = res0_ovf_q;
  assign res1_valid = res1_valid_q;
  assign res1_data  = res1_data_q;
  assign res1_ovf   = res1_ovf_q;
  assign mul_a      = mul_a_q;
  assign mul_b      = mul_b_q;
  assign busy       = busy_q;

endmodule

// File: tb/tb_mul_share_ctrl.sv
// Bench for mul_share_ctrl: directed cycle table plus randomized traffic
// checked against a transaction-level queue model.
module tb_mul_share_ctrl;

  logic       clock = 1'b0;
  logic       reset;
  logic       req0_valid, req1_valid;
  logic [4:0] req0_a, req0_b, req1_a, req1_b;
  logic       req0_ready, req1_ready;
  logic       res0_valid, res1_valid;
  logic [9:0] res0_data, res1_data;
  logic       res0_ovf, res1_ovf;
  logic       res0_ready, res1_ready;
  logic [4:0] mul_a, mul_b;
  logic [9:0] mul_result;
  logic       mul_overflow;
  logic       busy;

  int n_vec = 0;
  int n_err = 0;
  int cyc   = 0;

  always #5 clock = ~clock;

  // Stand-in for the multiplier tree; overflow flag is an arbitrary
  // function of the product so its routing is observable.
  assign mul_result   = 10'(mul_a) * 10'(mul_b);
  assign mul_overflow = (10'(mul_a) * 10'(mul_b)) > 10'd500;

  mul_share_ctrl #(.OP_W(5), .RES_W(10)) dut (
    .clock(clock), .reset(reset),
    .req0_valid(req0_valid), .req0_a(req0_a), .req0_b(req0_b), .req0_ready(req0_ready),
    .req1_valid(req1_valid), .req1_a(req1_a), .req1_b(req1_b), .req1_ready(req1_ready),
    .res0_valid(res0_valid), .res0_data(res0_data), .res0_ovf(res0_ovf), .res0_ready(res0_ready),
    .res1_valid(res1_valid), .res1_data(res1_data), .res1_ovf(res1_ovf), .res1_ready(res1_ready),
    .mul_a(mul_a), .mul_b(mul_b), .mul_result(mul_result), .mul_overflow(mul_overflow),
    .busy(busy)
  );

  task automatic chk(input string name, input int act, input int exp);
    n_vec++;
    if (act !== exp) begin
      n_err++;
      $display("FAIL %s cycle %0d: got %0d expected %0d", name, cyc, act, exp);
    end
  endtask

  task automatic drive(input int rst, input int v0, input int a0, input int b0,
                       input int v1, input int a1, input int b1,
                       input int rr0, input int rr1);
    reset      = rst[0];
    req0_valid = v0[0];
    req0_a     = 5'(a0);
    req0_b     = 5'(b0);
    req1_valid = v1[0];
    req1_a     = 5'(a1);
    req1_b     = 5'(b1);
    res0_ready = rr0[0];
    res1_ready = rr1[0];
  endtask

  typedef struct {
    int rst, v0, a0, b0, v1, a1, b1, rr0, rr1;
    int rdy0, rdy1, rv0, rv1, bsy, d0, d1, ma, mb;
  } vec_t;

  function automatic vec_t mk(input int rst, input int v0, input int a0, input int b0,
                              input int v1, input int a1, input int b1,
                              input int rr0, input int rr1,
                              input int rdy0, input int rdy1, input int rv0, input int rv1,
                              input int bsy, input int d0, input int d1,
                              input int ma, input int mb);
    vec_t v;
    v.rst = rst; v.v0 = v0; v.a0 = a0; v.b0 = b0; v.v1 = v1; v.a1 = a1; v.b1 = b1;
    v.rr0 = rr0; v.rr1 = rr1; v.rdy0 = rdy0; v.rdy1 = rdy1; v.rv0 = rv0; v.rv1 = rv1;
    v.bsy = bsy; v.d0 = d0; v.d1 = d1; v.ma = ma; v.mb = mb;
    return v;
  endfunction

  // Transaction-level reference model state.
  typedef struct { int owner; int prod; int ovf; } op_t;
  op_t infl[$];
  op_t buf0[$];
  op_t buf1[$];
  int  m_rr, m_a, m_b;

  function automatic op_t mkop(input int owner, input int a, input int b);
    op_t o;
    o.owner = owner;
    o.prod  = a * b;
    o.ovf   = (a * b > 500) ? 1 : 0;
    return o;
  endfunction

  function automatic int owner_in_flight(input int i);
    foreach (infl[k]) if (infl[k].owner == i) return 1;
    return 0;
  endfunction

  vec_t tbl[$];

  initial begin
    int rst, v0, a0, b0, v1, a1, b1, rr0, rr1;
    int ok0, ok1, c0, c1, g;

    // Directed cycle table: inputs for the cycle and outputs seen in it.
    tbl.push_back(mk(1,1,3,4,1,6,7,1,1, 0,0,0,0,0, 0,0, 0,0));
    tbl.push_back(mk(1,1,3,4,1,6,7,1,1, 0,0,0,0,0, 0,0, 0,0));
    tbl.push_back(mk(0,1,3,4,0,0,0,1,1, 1,0,0,0,0, 0,0, 0,0));
    tbl.push_back(mk(0,0,0,0,0,0,0,1,1, 0,0,0,0,1, 0,0, 3,4));
    tbl.push_back(mk(0,0,0,0,0,0,0,1,1, 0,0,1,0,1, 12,0, 3,4));
    tbl.push_back(mk(0,0,0,0,0,0,0,1,1, 0,0,0,0,0, 0,0, 3,4));
    tbl.push_back(mk(1,0,0,0,0,0,0,1,1, 0,0,0,0,0, 0,0, 3,4));
    tbl.push_back(mk(0,1,2,5,1,6,7,1,1, 1,0,0,0,0, 0,0, 0,0));
    tbl.push_back(mk(0,0,0,0,1,6,7,1,1, 0,1,0,0,1, 0,0, 2,5));
    tbl.push_back(mk(0,0,0,0,0,0,0,1,1, 0,0,1,0,1, 10,0, 6,7));
    tbl.push_back(mk(0,0,0,0,0,0,0,1,1, 0,0,0,1,1, 0,42, 6,7));
    tbl.push_back(mk(0,0,0,0,0,0,0,1,1, 0,0,0,0,0, 0,0, 6,7));
    tbl.push_back(mk(0,1,1,1,0,0,0,1,1, 1,0,0,0,0, 0,0, 6,7));
    tbl.push_back(mk(0,1,2,2,0,0,0,1,1, 0,0,0,0,1, 0,0, 1,1));
    tbl.push_back(mk(0,1,2,2,0,0,0,1,1, 1,0,1,0,1, 1,0, 1,1));
    tbl.push_back(mk(0,1,3,3,0,0,0,1,1, 0,0,0,0,1, 0,0, 2,2));
    tbl.push_back(mk(0,1,3,3,0,0,0,1,1, 1,0,1,0,1, 4,0, 2,2));
    tbl.push_back(mk(0,0,0,0,0,0,0,1,1, 0,0,0,0,1, 0,0, 3,3));
    tbl.push_back(mk(0,0,0,0,0,0,0,1,1, 0,0,1,0,1, 9,0, 3,3));
    tbl.push_back(mk(0,0,0,0,0,0,0,1,1, 0,0,0,0,0, 0,0, 3,3));
    tbl.push_back(mk(0,1,3,4,0,0,0,0,1, 1,0,0,0,0, 0,0, 3,3));
    tbl.push_back(mk(0,1,5,5,0,0,0,0,1, 0,0,0,0,1, 0,0, 3,4));
    tbl.push_back(mk(0,1,5,5,0,0,0,0,1, 0,0,1,0,1, 12,0, 3,4));
    tbl.push_back(mk(0,1,5,5,0,0,0,0,1, 0,0,1,0,1, 12,0, 3,4));
    tbl.push_back(mk(0,1,5,5,0,0,0,1,1, 1,0,1,0,1, 12,0, 3,4));
    tbl.push_back(mk(0,0,0,0,0,0,0,1,1, 0,0,0,0,1, 0,0, 5,5));
    tbl.push_back(mk(0,0,0,0,0,0,0,1,1, 0,0,1,0,1, 25,0, 5,5));
    tbl.push_back(mk(0,0,0,0,0,0,0,1,1, 0,0,0,0,0, 0,0, 5,5));
    tbl.push_back(mk(0,0,0,0,1,7,3,1,1, 0,1,0,0,0, 0,0, 5,5));
    tbl.push_back(mk(1,0,0,0,0,0,0,1,1, 0,0,0,0,1, 0,0, 7,3));
    tbl.push_back(mk(0,1,1,2,1,2,3,1,1, 1,0,0,0,0, 0,0, 0,0));
    tbl.push_back(mk(0,0,0,0,1,2,3,1,1, 0,1,0,0,1, 0,0, 1,2));
    tbl.push_back(mk(0,0,0,0,0,0,0,1,1, 0,0,1,0,1, 2,0, 2,3));
    tbl.push_back(mk(0,0,0,0,0,0,0,1,1, 0,0,0,1,1, 0,6, 2,3));
    tbl.push_back(mk(0,0,0,0,0,0,0,1,1, 0,0,0,0,0, 0,0, 2,3));

    // One unchecked reset edge so the table starts from known state.
    drive(1, 0,0,0, 0,0,0, 0,0);
    @(posedge clock);

    foreach (tbl[i]) begin
      @(negedge clock);
      cyc = i;
      drive(tbl[i].rst, tbl[i].v0, tbl[i].a0, tbl[i].b0,
            tbl[i].v1, tbl[i].a1, tbl[i].b1, tbl[i].rr0, tbl[i].rr1);
      #1;
      chk("t_req0_ready", int'(req0_ready), tbl[i].rdy0);
      chk("t_req1_ready", int'(req1_ready), tbl[i].rdy1);
      chk("t_res0_valid", int'(res0_valid), tbl[i].rv0);
      chk("t_res1_valid", int'(res1_valid), tbl[i].rv1);
      chk("t_busy",       int'(busy),       tbl[i].bsy);
      chk("t_mul_a",      int'(mul_a),      tbl[i].ma);
      chk("t_mul_b",      int'(mul_b),      tbl[i].mb);
      if (tbl[i].rv0 != 0) begin
        chk("t_res0_data", int'(res0_data), tbl[i].d0);
        chk("t_res0_ovf",  int'(res0_ovf),  0);
      end
      if (tbl[i].rv1 != 0) begin
        chk("t_res1_data", int'(res1_data), tbl[i].d1);
        chk("t_res1_ovf",  int'(res1_ovf),  0);
      end
    end

    // Randomized traffic against the queue model; cycle 0 resets both.
    for (int c = 0; c < 3000; c++) begin
      @(negedge clock);
      cyc = 1000 + c;
      rst = (c == 0 || $urandom_range(99) == 0) ? 1 : 0;
      v0  = ($urandom_range(9) < 7) ? 1 : 0;
      v1  = ($urandom_range(9) < 6) ? 1 : 0;
      a0  = int'($urandom_range(31)); b0 = int'($urandom_range(31));
      a1  = int'($urandom_range(31)); b1 = int'($urandom_range(31));
      rr0 = ($urandom_range(9) < 7) ? 1 : 0;
      rr1 = ($urandom_range(9) < 5) ? 1 : 0;
      drive(rst, v0, a0, b0, v1, a1, b1, rr0, rr1);
      #1;

      g = -1;
      if (rst == 0) begin
        ok0 = (owner_in_flight(0) == 0) && (buf0.size() == 0 || rr0 != 0);
        ok1 = (owner_in_flight(1) == 0) && (buf1.size() == 0 || rr1 != 0);
        c0  = (v0 != 0 && ok0) ? 1 : 0;
        c1  = (v1 != 0 && ok1) ? 1 : 0;
        if (c0 != 0 && c1 != 0) g = m_rr;
        else if (c0 != 0)       g = 0;
        else if (c1 != 0)       g = 1;
      end

      if (c > 0) begin
        chk("r_req0_ready", int'(req0_ready), (g == 0) ? 1 : 0);
        chk("r_req1_ready", int'(req1_ready), (g == 1) ? 1 : 0);
        chk("r_res0_valid", int'(res0_valid), (buf0.size() != 0) ? 1 : 0);
        chk("r_res1_valid", int'(res1_valid), (buf1.size() != 0) ? 1 : 0);
        chk("r_busy", int'(busy),
            (infl.size() != 0 || buf0.size() != 0 || buf1.size() != 0) ? 1 : 0);
        chk("r_mul_a", int'(mul_a), m_a);
        chk("r_mul_b", int'(mul_b), m_b);
        if (buf0.size() != 0) begin
          chk("r_res0_data", int'(res0_data), buf0[0].prod);
          chk("r_res0_ovf",  int'(res0_ovf),  buf0[0].ovf);
        end
        if (buf1.size() != 0) begin
          chk("r_res1_data", int'(res1_data), buf1[0].prod);
          chk("r_res1_ovf",  int'(res1_ovf),  buf1[0].ovf);
        end
      end

      // Advance the model across the coming clock edge.
      if (rst != 0) begin
        infl.delete(); buf0.delete(); buf1.delete();
        m_rr = 0; m_a = 0; m_b = 0;
      end else begin
        if (rr0 != 0 && buf0.size() != 0) void'(buf0.pop_front());
        if (rr1 != 0 && buf1.size() != 0) void'(buf1.pop_front());
        foreach (infl[k]) begin
          if (infl[k].owner == 0) buf0.push_back(infl[k]);
          else                    buf1.push_back(infl[k]);
        end
        infl.delete();
        if (g == 0) begin
          infl.push_back(mkop(0, a0, b0)); m_a = a0; m_b = b0; m_rr = 1;
        end else if (g == 1) begin
          infl.push_back(mkop(1, a1, b1)); m_a = a1; m_b = b1; m_rr = 0;
        end
      end
    end

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule
